// File: rtl/fetch_unit.sv
// fetch_unit: fetches NWORDS-word instructions from a single-outstanding
// memory port into a QDEPTH-entry queue feeding the decoder.
// Optional feature macro FETCH_HALT_EN: fetching stops after a halt opcode
// has been queued; without it the halt opcode is an ordinary instruction.
module fetch_unit #(
  parameter int WORD_W = 10,
  parameter int ADDR_W = 14,
  parameter int NWORDS = 3,
  parameter int QDEPTH = 2,
  parameter int OPC_W  = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h2000,
  parameter logic [OPC_W-1:0]  HALT_OPC = 5'b10011
) (
  input  logic                     clk_in,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_rvalid,
  input  logic [WORD_W-1:0]        mem_rdata,
  output logic                     instr_valid,
  output logic [NWORDS*WORD_W-1:0] instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     halted
);

  localparam int IW  = NWORDS * WORD_W;
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FULL, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [IW-1:0]     asm_q, asm_d;

  logic [IW-1:0]     q_data_q [QDEPTH];
  logic [IW-1:0]     q_data_d [QDEPTH];
  logic [ADDR_W-1:0] q_pc_q   [QDEPTH];
  logic [ADDR_W-1:0] q_pc_d   [QDEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic          push, pop, can_push;
  logic [IW-1:0] push_data;
  logic [IW-1:0] asm_new;
  logic          hit_new, hit_held;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Incoming word shifts in at the LSB end so the first word ends up in the MSBs.
  assign asm_new  = (asm_q << WORD_W) | IW'(mem_rdata);
  assign hit_new  = HALT_EN && (asm_new[IW-1 -: OPC_W] == HALT_OPC);
  assign hit_held = HALT_EN && (asm_q[IW-1 -: OPC_W] == HALT_OPC);

  assign instr_valid = (cnt_q != '0);
  assign instr_data  = q_data_q[rd_q];
  assign instr_pc    = q_pc_q[rd_q];
  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = fetch_pc_q;
  assign halted      = HALT_EN && (state_q == S_HALT);

  // A redirect voids any pop in its cycle; a full queue accepts a push when it pops.
  assign pop      = instr_valid && instr_ready && !redirect;
  assign can_push = (cnt_q < CW'(QDEPTH)) || pop;

  // Next-state logic: word assembly, push decision, redirect override.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wcnt_d     = wcnt_q;
    drop_d     = drop_q;
    ipc_d      = ipc_q;
    asm_d      = asm_q;
    push       = 1'b0;
    push_data  = asm_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (wcnt_q == '0) ipc_d = fetch_pc_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (wcnt_q == WCW'(NWORDS - 1)) begin
              wcnt_d    = '0;
              push_data = asm_new;
              if (can_push) begin
                push    = 1'b1;
                state_d = hit_new ? S_HALT : S_REQ;
              end else begin
                asm_d   = asm_new;
                state_d = S_FULL;
              end
            end else begin
              asm_d   = asm_new;
              wcnt_d  = wcnt_q + WCW'(1);
              state_d = S_REQ;
            end
          end
        end
      end
      S_FULL: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = hit_held ? S_HALT : S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Redirect wins over everything; a response still in flight must be swallowed.
    if (redirect) begin
      push       = 1'b0;
      wcnt_d     = '0;
      fetch_pc_d = redirect_pc;
      if ((state_q == S_WAIT) && !mem_rvalid) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  // Circular queue update; a redirect empties it while leaving the head slot intact.
  always_comb begin
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    if (redirect) begin
      wr_d  = rd_q;
      cnt_d = '0;
    end else begin
      if (push) begin
        q_data_d[wr_q] = push_data;
        q_pc_d[wr_q]   = ipc_q;
        wr_d           = ptr_inc(wr_q);
      end
      if (pop) rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control and queue registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      wcnt_q     <= '0;
      drop_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wcnt_q     <= wcnt_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      q_data_q   <= q_data_d;
      q_pc_q     <= q_pc_d;
    end
  end

  // Assembly datapath registers; their contents are only used under control qualification.
  always_ff @(posedge clk_in) begin
    asm_q <= asm_d;
    ipc_q <= ipc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory responder, instruction-stream
// model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;
  localparam int WORD_W = 10;
  localparam int ADDR_W = 14;
  localparam int NWORDS = 3;
  localparam int IW     = NWORDS * WORD_W;

  logic              clk_in = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid = 1'b0;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              instr_valid;
  logic [IW-1:0]     instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halted;

  int tests = 0;
  int fails = 0;
  int lat = 1;
  logic [WORD_W-1:0] ovr [int unsigned];

  fetch_unit dut (
    .clk_in(clk_in), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    if (ovr.exists({18'd0, a})) return ovr[{18'd0, a}];
    return {1'b0, a[8:0]};
  endfunction

  function automatic logic [IW-1:0] instr_at(input logic [ADDR_W-1:0] pc);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NWORDS; i++) r = (r << WORD_W) | IW'(word_at(pc + ADDR_W'(i)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_req(input int maxc, input string nm);
    for (int i = 0; i < maxc && mem_req !== 1'b1; i++) step();
    chk(nm, {63'd0, mem_req}, 64'd1);
  endtask

  task automatic wait_valid(input int maxc, input string nm);
    for (int i = 0; i < maxc && instr_valid !== 1'b1; i++) step();
    chk(nm, {63'd0, instr_valid}, 64'd1);
  endtask

  // Memory: one request at a time, response lat cycles after the request cycle.
  logic              rsp_pend = 1'b0;
  int                rsp_cnt = 0;
  logic [ADDR_W-1:0] rsp_addr = '0;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      mem_rvalid = 1'b0;
      if (rst) rsp_pend = 1'b0;
      else begin
        if (rsp_pend) begin
          if (rsp_cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_at(rsp_addr);
            rsp_pend   = 1'b0;
          end else rsp_cnt--;
        end
        if (mem_req && !rsp_pend) begin
          rsp_pend = 1'b1;
          rsp_cnt  = lat;
          rsp_addr = mem_addr;
        end
      end
    end
  end

  // Model: the head must be the instruction at the address the stream has reached.
  logic [ADDR_W-1:0] exp_pc = 14'h2000;
  logic prev_req = 1'b0;
  logic prev_redir = 1'b0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst) begin
        exp_pc = 14'h2000;
        prev_req = 1'b0;
        prev_redir = 1'b0;
      end else begin
        if (instr_valid) begin
          chk("model_pc", {50'd0, instr_pc}, {50'd0, exp_pc});
          chk("model_data", {34'd0, instr_data}, {34'd0, instr_at(exp_pc)});
        end
        if (prev_req && !prev_redir) chk("req_one_cycle", {63'd0, mem_req}, 64'd0);
        if (redirect) exp_pc = redirect_pc;
        else if (instr_valid && instr_ready) exp_pc = exp_pc + ADDR_W'(NWORDS);
        prev_req = mem_req;
        prev_redir = redirect;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    ovr[32'h2000] = 10'h3FF;
    ovr[32'h2001] = 10'h001;
    ovr[32'h2002] = 10'h155;
    repeat (3) step();
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {50'd0, mem_addr}, 64'h2000);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_data", {34'd0, instr_data}, 64'd0);
    chk("rst_pc", {50'd0, instr_pc}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0;
    repeat (6) step();
    chk("lat_c6_valid", {63'd0, instr_valid}, 64'd0);
    step();
    chk("lat_c7_valid", {63'd0, instr_valid}, 64'd1);
    chk("lat_c7_data", {34'd0, instr_data}, 64'h3FF00555);
    chk("lat_c7_pc", {50'd0, instr_pc}, 64'h2000);
    chk("lat_c7_req", {63'd0, mem_req}, 64'd1);
    chk("lat_c7_addr", {50'd0, mem_addr}, 64'h2003);
    // Back-pressure: third instruction parks, nothing requested.
    repeat (12) step();
    chk("bp_c19_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("bp_c20_req", {63'd0, mem_req}, 64'd0);
    chk("bp_c20_addr", {50'd0, mem_addr}, 64'h2009);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("bp_c21_req", {63'd0, mem_req}, 64'd1);
    chk("bp_c21_addr", {50'd0, mem_addr}, 64'h2009);
    chk("bp_c21_pc", {50'd0, instr_pc}, 64'h2003);
    repeat (6) step();
    chk("bp_c27_full_req", {63'd0, mem_req}, 64'd0);
    // Redirect with a simultaneous pop of a valid head, to a wrapping address.
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 14'h3FFE;
    step();
    redirect = 1'b0;
    instr_ready = 1'b0;
    chk("rd_c28_valid", {63'd0, instr_valid}, 64'd0);
    chk("rd_c28_pc_hold", {50'd0, instr_pc}, 64'h2003);
    chk("wrap_req0", {50'd0, mem_addr}, 64'h3FFE);
    chk("wrap_req0_v", {63'd0, mem_req}, 64'd1);
    step();
    wait_req(10, "wrap_req1_seen");
    chk("wrap_req1", {50'd0, mem_addr}, 64'h3FFF);
    step();
    wait_req(10, "wrap_req2_seen");
    chk("wrap_req2", {50'd0, mem_addr}, 64'h0000);
    chk("rd_pc_hold_late", {50'd0, instr_pc}, 64'h2003);
    instr_ready = 1'b1;
    wait_valid(20, "wrap_i0_seen");
    chk("wrap_i0_pc", {50'd0, instr_pc}, 64'h3FFE);
    chk("wrap_i0_data", {34'd0, instr_data}, 64'h1FE7FC00);
    step();
    wait_valid(20, "wrap_i1_seen");
    chk("wrap_i1_pc", {50'd0, instr_pc}, 64'h0001);
    // Redirect during WAIT with a slow, stale response.
    lat = 4;
    step();
    wait_req(20, "drop_req_seen");
    step();
    redirect = 1'b1;
    redirect_pc = 14'h0100;
    step();
    redirect = 1'b0;
    chk("drop_k2_valid", {63'd0, instr_valid}, 64'd0);
    chk("drop_k2_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("drop_k3_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("drop_k4_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("drop_k5_req", {63'd0, mem_req}, 64'd1);
    chk("drop_k5_addr", {50'd0, mem_addr}, 64'h0100);
    lat = 1;
    wait_valid(60, "drop_i_seen");
    chk("drop_i_pc", {50'd0, instr_pc}, 64'h0100);
    chk("drop_i_data", {34'd0, instr_data}, 64'h10040502);
    // Halt opcode at 0x2003.
    ovr[32'h2003] = 10'h260;
    for (int i = 0; i < 30 && mem_rvalid !== 1'b1; i++) step();
    chk("halt_sync_rvalid", {63'd0, mem_rvalid}, 64'd1);
    redirect = 1'b1;
    redirect_pc = 14'h2000;
    step();
    redirect = 1'b0;
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 80 && halted !== 1'b1; i++) step();
    chk("halt_reached", {63'd0, halted}, 64'd1);
    seen = 0;
    repeat (20) begin
      step();
      if (mem_req) seen++;
    end
    chk("halt_no_req", 64'(seen), 64'd0);
    chk("halt_still", {63'd0, halted}, 64'd1);
    chk("halt_drained", {63'd0, instr_valid}, 64'd0);
    redirect = 1'b1;
    redirect_pc = 14'h2000;
    step();
    redirect = 1'b0;
    chk("halt_exit", {63'd0, halted}, 64'd0);
    chk("halt_resume_req", {63'd0, mem_req}, 64'd1);
    chk("halt_resume_addr", {50'd0, mem_addr}, 64'h2000);
`else
    seen = 0;
    for (int i = 0; i < 80 && !(mem_req === 1'b1 && mem_addr === 14'h2006); i++) begin
      step();
      if (halted) seen++;
    end
    chk("nohalt_addr", {50'd0, mem_addr}, 64'h2006);
    chk("nohalt_never_halted", 64'(seen), 64'd0);
    repeat (10) step();
    chk("nohalt_halted", {63'd0, halted}, 64'd0);
`endif
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
